block_matmul_engine: RTL and testbench
======================================

Name: block_matmul_engine

Overview:
- Parametrised successor to the fixed 2x2-block matrix multiplier top.
- Computes C = A·B, or C += A·B in accumulate mode, for square DIM×DIM signed matrices (DIM = 2·BLK_N) held row-major in an external single-port RAM.
- Tiles the work into 2x2 blocks, fetches operands over a 1-cycle-latency RAM port, performs block multiply-accumulate internally and writes results back.
- Sits between the system control logic (start/done) and the shared data RAM.

Parameters:
DATA_W, 32, element width (signed two's complement)
ADDR_W, 9, RAM address width
BLK_N, 2, matrix dimension in 2x2 blocks (DIM = 2·BLK_N, BLK_N ≥ 1)
ACC_W, 2*DATA_W+8, internal accumulator width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; accepted only in IDLE
acc_mode  in  1  0: C = A·B; 1: C += A·B; latched on accept
a_base  in  ADDR_W  address of A[0][0]; latched on accept
b_base  in  ADDR_W  address of B[0][0]; latched on accept
c_base  in  ADDR_W  address of C[0][0]; latched on accept
busy  out  1  high from the cycle after accept through the done cycle
done  out  1  one-cycle pulse at completion
err  out  1  sticky overflow flag; cleared on next accepted start
mem_addr  out  ADDR_W  RAM address
mem_rd_en  out  1  read strobe; data valid on mem_rd_data the next cycle
mem_rd_data  in  DATA_W  RAM read data
mem_wr_en  out  1  write strobe
mem_wr_data  out  DATA_W  RAM write data

Behaviour:
- Reset: all outputs 0, FSM to IDLE, accumulators and counters cleared. rst mid-operation aborts immediately; no further RAM strobes. Partially written C is left as is.
- Element (r,c) of matrix X lives at x_base + r·DIM + c. Addresses wrap modulo 2^ADDR_W.
- States: IDLE, LOADC, FETCH, MAC, WRITE, DONE.
- IDLE:
  - start=1 latches the inputs, clears err, zeroes bi/bj/bk, goes to LOADC if acc_mode, else FETCH.
  - Entering FETCH also clears the 2x2 accumulator.
  - start while not IDLE is ignored.
- LOADC, 5 cycles:
  - Issues 4 reads of C block (bi,bj) in order 11,12,21,22.
  - Captures each word one cycle later, sign-extended into the accumulator.
  - Then FETCH.
- FETCH, 9 cycles:
  - Issues 8 reads on consecutive cycles: A block (bi,bk) 11,12,21,22, then B block (bk,bj) 11,12,21,22.
  - The 9th cycle captures the last word. Then MAC.
- MAC, 1 cycle:
  - acc_ij += A_i1·B_1j + A_i2·B_2j, full-precision signed, in ACC_W.
  - If bk < BLK_N-1: bk++, go to FETCH. Else go to WRITE.
- WRITE, 4 cycles:
  - Writes block 11,12,21,22 to C. mem_wr_data is the low DATA_W bits of the accumulator (wrap).
  - err is set if any written value lies outside the signed DATA_W range.
  - Then advance bj, then bi, row-major. Next block goes to LOADC or FETCH per the latched mode; after the last block go to DONE.
- DONE, 1 cycle: done=1, busy=1; then IDLE.
- mem_rd_en and mem_wr_en are never high in the same cycle. mem_addr is don't-care when both are low, but must be stable (no X).
- Latency from the accept edge to the done cycle: L = BLK_N²·(10·BLK_N + 4 + 5·acc_mode) + 1 cycles. Exact; the bench checks it.
- Aliasing: if C overlaps A or B, results are undefined and no error is flagged.

Decomposition:
- Package block_matmul_pkg: state enum, block element index constants (E11, E12, E21, E22), FETCH/LOADC/WRITE phase lengths, and the latency function.
- Sub-module block_mac_2x2: combinational 2x2 block multiply-add in ACC_W with a per-element signed-DATA_W range check.
- FSM, address generation and capture registers live in block_matmul_engine.

Test Plan:
- BLK_N=1, A=I, B=[[1,2],[3,4]], acc_mode=0 -> RAM writes 1,2,3,4 at c_base..c_base+3; done exactly 15 cycles after accept; err=0.
- BLK_N=2, A[r][c]=r+c, B=I4 -> C equals A element-for-element; done after 4·(20+4)+1=97 cycles; exactly 16 write strobes, addresses in block order.
- BLK_N=1, acc_mode=1, C preloaded [[10,10],[10,10]], A=B=[[1,1],[1,1]] -> C=[[12,12],[12,12]]; done after 20 cycles.
- DATA_W=8, BLK_N=1, A=[[100,0],[0,0]], B=[[100,0],[0,0]] -> C[0][0] written 0x10, err=1 and held. Next start with zero matrices -> err clears.
- Pulse start again while busy -> ignored, latency unchanged, only one done pulse.
- Assert rst mid-FETCH -> next cycle busy=0, no RAM strobes, FSM IDLE. A fresh start then completes correctly.

Source files
------------

// File: rtl/block_matmul_pkg.sv
// Shared types and constants for the tiled 2x2-block matrix multiply engine.
// Also holds the address-offset and latency helpers used by the engine.
package block_matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADC,
        FETCH,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Element positions inside a 2x2 block, row-major.
    localparam logic [1:0] E11 = 2'd0;
    localparam logic [1:0] E12 = 2'd1;
    localparam logic [1:0] E21 = 2'd2;
    localparam logic [1:0] E22 = 2'd3;

    localparam int LOADC_CYCLES = 5;
    localparam int FETCH_CYCLES = 9;
    localparam int WRITE_CYCLES = 4;

    function automatic int latency(input int blk_n, input bit acc_mode);
        return blk_n * blk_n * (blk_n * (FETCH_CYCLES + 1) + WRITE_CYCLES
               + (acc_mode ? LOADC_CYCLES : 0)) + 1;
    endfunction

    // Word offset of element e of block (br, bc) in a dim x dim row-major matrix.
    function automatic int elem_offset(input int dim, input int br, input int bc,
                                       input logic [1:0] e);
        return (2 * br + int'(e[1])) * dim + 2 * bc + int'(e[0]);
    endfunction

endpackage

// File: rtl/block_matmul_engine_mac.sv
// Combinational 2x2 block multiply-add in ACC_W precision, flagging results
// that do not fit back into a signed DATA_W word.
module block_mac_2x2
    import block_matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 2 * DATA_W + 8
) (
    input  logic signed [ACC_W-1:0]  acc_in  [4],
    input  logic signed [DATA_W-1:0] a       [4],
    input  logic signed [DATA_W-1:0] b       [4],
    output logic signed [ACC_W-1:0]  acc_out [4],
    output logic [3:0]               ovf
);

    function automatic logic signed [ACC_W-1:0] prod(input logic signed [DATA_W-1:0] x,
                                                     input logic signed [DATA_W-1:0] y);
        return ACC_W'(x) * ACC_W'(y);
    endfunction

    // A value fits when every bit from the DATA_W sign bit upward agrees.
    function automatic logic fits(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] hi;
        hi = v[ACC_W-1:DATA_W-1];
        return (&hi) || !(|hi);
    endfunction

    always_comb begin
        acc_out[E11] = acc_in[E11] + prod(a[E11], b[E11]) + prod(a[E12], b[E21]);
        acc_out[E12] = acc_in[E12] + prod(a[E11], b[E12]) + prod(a[E12], b[E22]);
        acc_out[E21] = acc_in[E21] + prod(a[E21], b[E11]) + prod(a[E22], b[E21]);
        acc_out[E22] = acc_in[E22] + prod(a[E21], b[E12]) + prod(a[E22], b[E22]);
        for (int i = 0; i < 4; i++) begin
            ovf[i] = !fits(acc_out[i]);
        end
    end

endmodule

// File: rtl/block_matmul_engine.sv
// Tiled signed matrix multiplier: C = A*B or C += A*B over DIM x DIM matrices
// in a shared single-port RAM, processed one 2x2 block at a time.
module block_matmul_engine
    import block_matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int BLK_N  = 2,
    parameter int ACC_W  = 2 * DATA_W + 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acc_mode,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] c_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data
);

    localparam int DIM   = 2 * BLK_N;
    localparam int IDX_W = (BLK_N > 1) ? $clog2(BLK_N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_N - 1);
    localparam logic [3:0] LOADC_LAST = 4'(LOADC_CYCLES - 1);
    localparam logic [3:0] FETCH_LAST = 4'(FETCH_CYCLES - 1);
    localparam logic [3:0] WRITE_LAST = 4'(WRITE_CYCLES - 1);

    state_t                    state;
    logic [3:0]                cnt;
    logic [IDX_W-1:0]          bi, bj, bk;
    logic                      acc_mode_q;
    logic [ADDR_W-1:0]         a_base_q, b_base_q, c_base_q;
    logic signed [ACC_W-1:0]   acc     [4];
    logic signed [DATA_W-1:0]  a_reg   [4];
    logic signed [DATA_W-1:0]  b_reg   [4];
    logic signed [ACC_W-1:0]   mac_out [4];
    logic [3:0]                mac_ovf;
    logic [3:0]                ovf_q;

    logic [3:0]                cnt_inc;
    logic [2:0]                cnt_dec;
    logic                      last_bj, last_block;
    logic [IDX_W-1:0]          nxt_bi, nxt_bj;

    assign cnt_inc    = cnt + 4'd1;
    assign cnt_dec    = 3'(cnt - 4'd1);
    assign last_bj    = (bj == LAST_IDX);
    assign last_block = last_bj && (bi == LAST_IDX);
    assign nxt_bj     = last_bj ? '0 : bj + 1'b1;
    assign nxt_bi     = last_bj ? bi + 1'b1 : bi;

    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  br,
                                                    input logic [IDX_W-1:0]  bc,
                                                    input logic [1:0]        e);
        return base + ADDR_W'(elem_offset(DIM, int'(br), int'(bc), e));
    endfunction

    block_mac_2x2 #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc_in  (acc),
        .a       (a_reg),
        .b       (b_reg),
        .acc_out (mac_out),
        .ovf     (mac_ovf)
    );

    // RAM strobes and address are registered: each transition below sets up
    // the bus for the cycle being entered, so reads land one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bi          <= '0;
            bj          <= '0;
            bk          <= '0;
            acc_mode_q  <= 1'b0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            c_base_q    <= '0;
            ovf_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            for (int i = 0; i < 4; i++) begin
                acc[i]   <= '0;
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_mode_q <= acc_mode;
                        a_base_q   <= a_base;
                        b_base_q   <= b_base;
                        c_base_q   <= c_base;
                        err        <= 1'b0;
                        bi         <= '0;
                        bj         <= '0;
                        bk         <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        mem_rd_en  <= 1'b1;
                        if (acc_mode) begin
                            state    <= LOADC;
                            mem_addr <= elem_addr(c_base, '0, '0, E11);
                        end else begin
                            state    <= FETCH;
                            mem_addr <= elem_addr(a_base, '0, '0, E11);
                            for (int i = 0; i < 4; i++) acc[i] <= '0;
                        end
                    end
                end

                LOADC: begin
                    if (cnt != 4'd0) acc[cnt_dec[1:0]] <= ACC_W'(signed'(mem_rd_data));
                    if (cnt == LOADC_LAST) begin
                        state     <= FETCH;
                        cnt       <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= elem_addr(a_base_q, bi, bk, E11);
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc != LOADC_LAST) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= elem_addr(c_base_q, bi, bj, cnt_inc[1:0]);
                        end
                    end
                end

                // Words 0-3 are the A block, words 4-7 the B block.
                FETCH: begin
                    if (cnt != 4'd0) begin
                        if (cnt_dec[2]) b_reg[cnt_dec[1:0]] <= signed'(mem_rd_data);
                        else            a_reg[cnt_dec[1:0]] <= signed'(mem_rd_data);
                    end
                    if (cnt == FETCH_LAST) begin
                        state <= MAC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc != FETCH_LAST) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= cnt_inc[2] ? elem_addr(b_base_q, bk, bj, cnt_inc[1:0])
                                                    : elem_addr(a_base_q, bi, bk, cnt_inc[1:0]);
                        end
                    end
                end

                MAC: begin
                    for (int i = 0; i < 4; i++) acc[i] <= mac_out[i];
                    if (bk != LAST_IDX) begin
                        bk        <= bk + 1'b1;
                        state     <= FETCH;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= elem_addr(a_base_q, bi, bk + 1'b1, E11);
                    end else begin
                        state       <= WRITE;
                        ovf_q       <= mac_ovf;
                        err         <= err | mac_ovf[E11];
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= elem_addr(c_base_q, bi, bj, E11);
                        mem_wr_data <= mac_out[E11][DATA_W-1:0];
                    end
                end

                WRITE: begin
                    if (cnt == WRITE_LAST) begin
                        cnt <= '0;
                        if (last_block) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            bi        <= nxt_bi;
                            bj        <= nxt_bj;
                            bk        <= '0;
                            mem_rd_en <= 1'b1;
                            if (acc_mode_q) begin
                                state    <= LOADC;
                                mem_addr <= elem_addr(c_base_q, nxt_bi, nxt_bj, E11);
                            end else begin
                                state    <= FETCH;
                                mem_addr <= elem_addr(a_base_q, nxt_bi, '0, E11);
                                for (int i = 0; i < 4; i++) acc[i] <= '0;
                            end
                        end
                    end else begin
                        cnt         <= cnt_inc;
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= elem_addr(c_base_q, bi, bj, cnt_inc[1:0]);
                        mem_wr_data <= acc[cnt_inc[1:0]][DATA_W-1:0];
                        err         <= err | ovf_q[cnt_inc[1:0]];
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_matmul_engine.sv
// Scoreboard bench for block_matmul_engine: one 32-bit BLK_N=2 instance and
// one 8-bit BLK_N=1 instance, each behind its own RAM model.
module tb_block_matmul_engine;

    localparam int AW = 9;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } sb_entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, acc_mode, sel;
    logic [AW-1:0] a_base, b_base, c_base;
    logic          start32, start8;

    logic          busy32, done32, err32, rd32, wr32;
    logic [AW-1:0] addr32;
    logic [31:0]   rdata32, wdata32;

    logic          busy8, done8, err8, rd8, wr8;
    logic [AW-1:0] addr8;
    logic [7:0]    rdata8, wdata8;

    logic          sel_busy, sel_done, sel_err;

    int            checks = 0;
    int            errors = 0;
    sb_entry_t     sb32[$];
    sb_entry_t     sb8[$];
    sb_entry_t     e32, e8;
    logic [31:0]   ram32 [512];
    logic [7:0]    ram8  [512];
    longint        ma [4][4];
    longint        mb [4][4];
    longint        mc [4][4];

    assign start32  = start & ~sel;
    assign start8   = start & sel;
    assign sel_busy = sel ? busy8 : busy32;
    assign sel_done = sel ? done8 : done32;
    assign sel_err  = sel ? err8  : err32;

    block_matmul_engine #(.DATA_W(32), .ADDR_W(AW), .BLK_N(2)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .acc_mode(acc_mode),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .busy(busy32), .done(done32), .err(err32),
        .mem_addr(addr32), .mem_rd_en(rd32), .mem_rd_data(rdata32),
        .mem_wr_en(wr32), .mem_wr_data(wdata32)
    );

    block_matmul_engine #(.DATA_W(8), .ADDR_W(AW), .BLK_N(1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .acc_mode(acc_mode),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .busy(busy8), .done(done8), .err(err8),
        .mem_addr(addr8), .mem_rd_en(rd8), .mem_rd_data(rdata8),
        .mem_wr_en(wr8), .mem_wr_data(wdata8)
    );

    // RAM models only serve reads; DUT writes are judged by the scoreboards.
    always @(posedge clk) begin
        if (rd32) rdata32 <= ram32[addr32];
        if (rd8)  rdata8  <= ram8[addr8];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rd32 && wr32) checkOutput("rdwr32_overlap", 64'd1, 64'd0);
        if (wr32) begin
            if (sb32.size() == 0) begin
                checkOutput("wr32_pending", 64'(sb32.size()), 64'd1);
            end else begin
                e32 = sb32.pop_front();
                checkOutput("wr32_addr", 64'(addr32), 64'(e32.addr));
                checkOutput("wr32_data", 64'(wdata32), 64'(e32.data));
            end
        end
    end

    always @(negedge clk) begin
        if (rd8 && wr8) checkOutput("rdwr8_overlap", 64'd1, 64'd0);
        if (wr8) begin
            if (sb8.size() == 0) begin
                checkOutput("wr8_pending", 64'(sb8.size()), 64'd1);
            end else begin
                e8 = sb8.pop_front();
                checkOutput("wr8_addr", 64'(addr8), 64'(e8.addr));
                checkOutput("wr8_data", 64'(wdata8), 64'(e8.data));
            end
        end
    end

    // Loads ma/mb/mc into the selected RAM and queues the expected C writes.
    task automatic buildExpect(input bit s, input bit acc, input int dim,
                               input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                               input logic [AW-1:0] cb, output bit exp_err);
        int            w, r, c;
        longint        lo, hi, sum;
        logic [AW-1:0] ad;
        sb_entry_t     ent;
        w  = s ? 8 : 32;
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        exp_err = 1'b0;
        for (int i = 0; i < dim; i++) begin
            for (int j = 0; j < dim; j++) begin
                if (s) begin
                    ad = ab + AW'(i * dim + j); ram8[ad] = 8'(ma[i][j]);
                    ad = bb + AW'(i * dim + j); ram8[ad] = 8'(mb[i][j]);
                    ad = cb + AW'(i * dim + j); ram8[ad] = 8'(mc[i][j]);
                end else begin
                    ad = ab + AW'(i * dim + j); ram32[ad] = 32'(ma[i][j]);
                    ad = bb + AW'(i * dim + j); ram32[ad] = 32'(mb[i][j]);
                    ad = cb + AW'(i * dim + j); ram32[ad] = 32'(mc[i][j]);
                end
            end
        end
        for (int bi = 0; bi < dim / 2; bi++) begin
            for (int bj = 0; bj < dim / 2; bj++) begin
                for (int e = 0; e < 4; e++) begin
                    r   = 2 * bi + e / 2;
                    c   = 2 * bj + e % 2;
                    sum = acc ? mc[r][c] : 0;
                    for (int k = 0; k < dim; k++) sum += ma[r][k] * mb[k][c];
                    if (sum < lo || sum > hi) exp_err = 1'b1;
                    ent.addr = cb + AW'(r * dim + c);
                    ent.data = s ? {24'd0, 8'(sum)} : 32'(sum);
                    if (s) sb8.push_back(ent);
                    else   sb32.push_back(ent);
                end
            end
        end
    endtask

    task automatic applyStimulus(input string name, input bit s, input bit acc, input int dim,
                                 input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                                 input logic [AW-1:0] cb, input bit poke);
        int n, lat, cycles;
        bit exp_err;
        n   = dim / 2;
        lat = n * n * (10 * n + 4 + (acc ? 5 : 0)) + 1;
        buildExpect(s, acc, dim, ab, bb, cb, exp_err);
        sel = s; acc_mode = acc; a_base = ab; b_base = bb; c_base = cb;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        checkOutput({name, "_busy_on_accept"}, 64'(sel_busy), 64'd1);
        checkOutput({name, "_err_cleared"}, 64'(sel_err), 64'd0);
        while (sel_done !== 1'b1 && cycles < lat + 64) begin
            start = poke && (cycles == 3);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        checkOutput({name, "_latency"}, 64'(cycles), 64'(lat));
        checkOutput({name, "_err"}, 64'(sel_err), 64'(exp_err));
        checkOutput({name, "_busy_at_done"}, 64'(sel_busy), 64'd1);
        @(posedge clk); #1;
        checkOutput({name, "_done_single"}, 64'(sel_done), 64'd0);
        checkOutput({name, "_busy_idle"}, 64'(sel_busy), 64'd0);
        checkOutput({name, "_writes_drained"}, 64'(s ? sb8.size() : sb32.size()), 64'd0);
    endtask

    task automatic setMats(input int dim, input longint av, input longint bv, input longint cv);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i < dim && j < dim) ? av : 0;
                mb[i][j] = (i < dim && j < dim) ? bv : 0;
                mc[i][j] = (i < dim && j < dim) ? cv : 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit dummy_err;
        rst = 1'b1; start = 1'b0; acc_mode = 1'b0; sel = 1'b0;
        a_base = '0; b_base = '0; c_base = '0;
        for (int i = 0; i < 512; i++) begin
            ram32[i] = '0;
            ram8[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy32", 64'(busy32), 64'd0);
        checkOutput("reset_done32", 64'(done32), 64'd0);
        checkOutput("reset_err32", 64'(err32), 64'd0);
        checkOutput("reset_strobes32", 64'({rd32, wr32}), 64'd0);
        checkOutput("reset_addr32", 64'(addr32), 64'd0);
        checkOutput("reset_wdata32", 64'(wdata32), 64'd0);
        checkOutput("reset_ctrl8", 64'({busy8, done8, err8, rd8, wr8}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // BLK_N=1: identity times [[1,2],[3,4]].
        setMats(2, 0, 0, 0);
        ma[0][0] = 1; ma[1][1] = 1;
        mb[0][0] = 1; mb[0][1] = 2; mb[1][0] = 3; mb[1][1] = 4;
        applyStimulus("ident2", 1'b1, 1'b0, 2, 9'd16, 9'd20, 9'd24, 1'b0);

        // BLK_N=1 accumulate: 10 + 1*1 + 1*1 = 12 everywhere.
        setMats(2, 1, 1, 10);
        applyStimulus("accum2", 1'b1, 1'b1, 2, 9'd32, 9'd36, 9'd40, 1'b0);

        // 8-bit overflow: 100*100 wraps to 0x10 and raises err.
        setMats(2, 0, 0, 0);
        ma[0][0] = 100; mb[0][0] = 100;
        applyStimulus("ovf8", 1'b1, 1'b0, 2, 9'd48, 9'd52, 9'd56, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ovf8_err_held", 64'(err8), 64'd1);
        setMats(2, 0, 0, 0);
        applyStimulus("zero8", 1'b1, 1'b0, 2, 9'd48, 9'd52, 9'd56, 1'b0);

        // BLK_N=2: A[r][c] = r+c times identity.
        setMats(4, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) ma[i][j] = i + j;
            mb[i][i] = 1;
        end
        applyStimulus("ident4", 1'b0, 1'b0, 4, 9'd0, 9'd32, 9'd64, 1'b0);
        applyStimulus("busy_start", 1'b0, 1'b0, 4, 9'd0, 9'd32, 9'd64, 1'b1);

        // Signed random accumulate with C wrapping past the top of RAM.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = longint'($urandom_range(0, 2000)) - 1000;
                mb[i][j] = longint'($urandom_range(0, 2000)) - 1000;
                mc[i][j] = longint'($urandom_range(0, 2000)) - 1000;
            end
        end
        applyStimulus("rand_acc4", 1'b0, 1'b1, 4, 9'd100, 9'd200, 9'd500, 1'b0);

        // Reset in the middle of the first FETCH, then a clean rerun.
        setMats(4, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) ma[i][j] = i + j;
            mb[i][i] = 1;
        end
        buildExpect(1'b0, 1'b0, 4, 9'd0, 9'd32, 9'd64, dummy_err);
        sel = 1'b0; acc_mode = 1'b0; a_base = 9'd0; b_base = 9'd32; c_base = 9'd64;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_busy", 64'(busy32), 64'd0);
        checkOutput("rst_mid_strobes", 64'({rd32, wr32}), 64'd0);
        checkOutput("rst_mid_done", 64'(done32), 64'd0);
        rst = 1'b0;
        sb32.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("rst_quiet", 64'({rd32, wr32, busy32}), 64'd0);
        end
        applyStimulus("after_rst", 1'b0, 1'b0, 4, 9'd0, 9'd32, 9'd64, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
